// File: rtl/pe_ran_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_ran_pkg : shared constants and helpers for the random-mutation PE array
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
package pe_ran_pkg;

  localparam logic [1:0] NUC_A = 2'b00;
  localparam logic [1:0] NUC_C = 2'b01;
  localparam logic [1:0] NUC_G = 2'b10;
  localparam logic [1:0] NUC_T = 2'b11;

  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
  localparam logic [31:0] LANE_SEED_MIX = 32'h9E37_79B9;

  // The all-zero state would lock the LFSR, so it is remapped to 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int idx);
    logic [31:0] v;
    v = base ^ (32'(idx) * LANE_SEED_MIX);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_ran_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_ran_lane : one nucleotide lane - LFSR, scaled draw and cumulative select
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
module pe_ran_lane
  import pe_ran_pkg::*;
#(
  parameter int          IDX    = 0,
  parameter int          PROB_W = 10,
  parameter int          SCALE  = 1000,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_load,
  input  logic [31:0]           seed_in,
  input  logic                  accept,
  input  logic [1:0]            nuc_in,
  input  logic [16*PROB_W-1:0]  matrix,
  output logic [1:0]            nuc_out
);

  localparam int SUM_W  = PROB_W + 2;
  localparam int PROD_W = 16 + SUM_W;

  logic [31:0]       r_lfsr;
  logic [SUM_W-1:0]  r_draw;
  logic [PROD_W-1:0] w_prod;
  logic [SUM_W-1:0]  w_draw;
  logic [SUM_W-1:0]  w_sum;
  logic [1:0]        w_sel;
  logic              w_hit;

  assign w_prod = r_lfsr[15:0] * PROD_W'(SCALE);
  assign w_draw = SUM_W'(w_prod >> 16);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= lane_seed(SEED, IDX);
      r_draw <= '0;
    end else begin
      if (accept) r_draw <= w_draw;
      // A reload beats the advance; the accepted word already used the old draw.
      if (seed_load)   r_lfsr <= lane_seed(seed_in, IDX);
      else if (accept) r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  always_comb begin
    w_sum = '0;
    w_sel = nuc_in;
    w_hit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      w_sum = w_sum + SUM_W'(matrix[(4 * int'(nuc_in) + c) * PROB_W +: PROB_W]);
      if (!w_hit && (r_draw < w_sum)) begin
        w_hit = 1'b1;
        w_sel = 2'(c);
      end
    end
  end

  assign nuc_out = w_sel;

endmodule
`default_nettype wire

// File: rtl/pe_ran_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_ran_array : LANES-wide random nucleotide mutation, 2-stage valid/ready
//                pipeline. Optional mut_count output via PE_RAN_MUTCOUNT_EN.
// Rev 1.0      : initial release
// ---------------------------------------------------------------------------
module pe_ran_array
  import pe_ran_pkg::*;
#(
  parameter int          LANES  = 16,
  parameter int          PROB_W = 10,
  parameter int          SCALE  = 1000,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_load,
  input  logic [31:0]           seed_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LANES-1:0]    nucl_alig,
  input  logic [16*PROB_W-1:0]  matrix_P,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LANES-1:0]    final_result
`ifdef PE_RAN_MUTCOUNT_EN
  ,
  output logic [$clog2(LANES+1)-1:0] mut_count
`endif
);

  localparam int DW = 2 * LANES;

  logic                 r_s1_valid;
  logic [DW-1:0]        r_s1_word;
  logic [16*PROB_W-1:0] r_s1_matrix;
  logic                 r_out_valid;
  logic [DW-1:0]        r_result;
  logic [DW-1:0]        w_sel_word;
  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_accept;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;

  assign in_ready     = w_s1_adv;
  assign out_valid    = r_out_valid;
  assign final_result = r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_word   <= '0;
      r_s1_matrix <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_word   <= nucl_alig;
        r_s1_matrix <= matrix_P;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_result <= w_sel_word;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_ran_lane #(
      .IDX    (i),
      .PROB_W (PROB_W),
      .SCALE  (SCALE),
      .SEED   (SEED)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .accept    (w_accept),
      .nuc_in    (r_s1_word[2*i +: 2]),
      .matrix    (r_s1_matrix),
      .nuc_out   (w_sel_word[2*i +: 2])
    );
  end

`ifdef PE_RAN_MUTCOUNT_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] w_mut;
  logic [CNT_W-1:0] r_mut;

  always_comb begin
    w_mut = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_sel_word[2*i +: 2] != r_s1_word[2*i +: 2]) w_mut = w_mut + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         r_mut <= '0;
    else if (w_s2_adv && r_s1_valid)   r_mut <= w_mut;
  end

  assign mut_count = r_mut;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_ran_array.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pe_ran_array : scoreboard bench for pe_ran_array (PE_RAN_MUTCOUNT_EN aware)
// Rev 1.0         : initial release
// ---------------------------------------------------------------------------
module tb_pe_ran_array;

  localparam int          LANES  = 16;
  localparam int          PROB_W = 10;
  localparam int          SCALE  = 1000;
  localparam logic [31:0] SEED   = 32'hACE1_2468;
  localparam int          DW     = 2 * LANES;
  localparam int          PW_ALL = 16 * PROB_W;
  localparam int          CW     = $clog2(LANES + 1);
  localparam int          NWORDS = 4000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              seed_load = 1'b0;
  logic [31:0]       seed_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     nucl_alig = '0;
  logic [PW_ALL-1:0] matrix_P = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     final_result;
`ifdef PE_RAN_MUTCOUNT_EN
  logic [CW-1:0]     mut_count;
`endif

  pe_ran_array #(
    .LANES(LANES), .PROB_W(PROB_W), .SCALE(SCALE), .SEED(SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .nucl_alig    (nucl_alig),
    .matrix_P     (matrix_P),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .final_result (final_result)
`ifdef PE_RAN_MUTCOUNT_EN
    ,
    .mut_count    (mut_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] cap[$];
  logic [DW-1:0] stream1[$];
  logic [DW-1:0] ws[NWORDS];
  logic [31:0]   m_lfsr[LANES];
  int            total = 0;
  int            bad = 0;
  int            inflight = 0;
  int            nout = 0;
  bit            capture = 1'b0;
  bit            last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_seed(input logic [31:0] b, input int i);
    logic [31:0] v;
    v = b ^ (32'(i) * 32'h9E37_79B9);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_lfsr[i] = m_seed(SEED, i);
  endtask

  // Reference mutation of one accepted word; pushes the expected result.
  task automatic model_accept(input logic [DW-1:0] w, input logic [PW_ALL-1:0] p);
    exp_t e;
    int   r, acc, oi;
    bit   hit;
    logic [1:0] n;
    e.res = '0;
    e.mc  = '0;
    for (int i = 0; i < LANES; i++) begin
      oi  = int'(w[2*i +: 2]);
      r   = int'(({16'd0, m_lfsr[i][15:0]} * 32'(SCALE)) >> 16);
      n   = 2'(oi);
      acc = 0;
      hit = 1'b0;
      for (int c = 0; c < 4; c++) begin
        acc += int'(p[(4*oi + c)*PROB_W +: PROB_W]);
        if (!hit && r < acc) begin
          hit = 1'b1;
          n   = 2'(c);
        end
      end
      e.res[2*i +: 2] = n;
      if (int'(n) != oi) e.mc = e.mc + CW'(1);
      m_lfsr[i] = m_step(m_lfsr[i]);
    end
    sb.push_back(e);
  endtask

  function automatic logic [PW_ALL-1:0] mkp(input int mode);
    logic [PW_ALL-1:0] p;
    int v;
    p = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0:       v = (r == c) ? SCALE : 0;
          1:       v = (c == 3) ? SCALE : 0;
          2:       v = 0;
          3:       v = SCALE / 4;
          default: v = 100 * (((r + c) % 4) + 1);
        endcase
        p[(4*r + c)*PROB_W +: PROB_W] = PROB_W'(v);
      end
    end
    return p;
  endfunction

  // One clock of stimulus: drive after the edge, account at the negedge.
  task automatic cyc(input logic v, input logic [DW-1:0] w, input logic [PW_ALL-1:0] p,
                     input logic ordy, input logic sl, input logic [31:0] si);
    logic xfer;
    in_valid = v; nucl_alig = w; matrix_P = p; out_ready = ordy;
    seed_load = sl; seed_in = si;
    @(negedge clk);
    chk("in_ready", in_ready, (inflight < 2 || ordy) ? 1 : 0);
    xfer     = out_valid && out_ready;
    last_acc = v && in_ready;
    if (last_acc) model_accept(w, p);
    if (sl) for (int i = 0; i < LANES; i++) m_lfsr[i] = m_seed(si, i);
    inflight = inflight + int'(last_acc) - int'(xfer);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sb.delete();
    inflight = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && inflight > 0; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("drain_empty", inflight, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic send(input logic [DW-1:0] w, input logic [PW_ALL-1:0] p, input bit stall);
    logic v, o;
    for (int t = 0; t < 64; t++) begin
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      o = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc(v, w, p, o, 1'b0, '0);
      if (last_acc) return;
    end
    chk("send_accept", last_acc, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      nout++;
      if (sb.size() == 0) begin
        chk("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("result", final_result, e.res);
`ifdef PE_RAN_MUTCOUNT_EN
        chk("mut_count", mut_count, e.mc);
`endif
        if (capture) cap.push_back(final_result);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bpw[4];
    logic [DW-1:0] pr;
    logic          pv, o;
    int            k, n0, mism;
    int            cnt[4];

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_final_result", final_result, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef PE_RAN_MUTCOUNT_EN
    chk("rst_mut_count", mut_count, 0);
`endif

    // Identity matrix and two-cycle latency
    cyc(1'b1, 32'h5165_2D55, mkp(0), 1'b1, 1'b0, '0);
    chk("id_not_yet_valid", out_valid, 0);
    cyc(1'b0, '0, mkp(0), 1'b1, 1'b0, '0);
    chk("id_valid_at_2", out_valid, 1);
    chk("id_result", final_result, 32'h5165_2D55);
    drain();

    // Every row forces T
    cyc(1'b1, 32'h1B1B_E4E4, mkp(1), 1'b1, 1'b0, '0);
    cyc(1'b0, '0, mkp(1), 1'b1, 1'b0, '0);
    chk("allT_result", final_result, 32'hFFFF_FFFF);
`ifdef PE_RAN_MUTCOUNT_EN
    chk("allT_mut_count", mut_count, 12);
`endif
    drain();

    // All-zero matrix falls back to the original nucleotide
    cyc(1'b1, 32'hAAAA_AAAA, mkp(2), 1'b1, 1'b0, '0);
    cyc(1'b0, '0, mkp(2), 1'b1, 1'b0, '0);
    chk("zero_result", final_result, 32'hAAAA_AAAA);
    drain();

    // Back-to-back words with out_ready low for cycles 3..7
    bpw[0] = 32'h0123_4567; bpw[1] = 32'h89AB_CDEF;
    bpw[2] = 32'hDEAD_BEEF; bpw[3] = 32'h1357_9BDF;
    k  = 0;
    n0 = nout;
    for (int c = 0; c < 16; c++) begin
      o  = !(c >= 3 && c <= 7);
      pv = out_valid && !o;
      pr = final_result;
      cyc(k < 4, (k < 4) ? bpw[k] : '0, mkp(4), o, 1'b0, '0);
      if (last_acc) k++;
      if (pv) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", final_result, pr);
      end
    end
    chk("bp_all_sent", k, 4);
    drain();
    chk("bp_delivered", nout - n0, 4);

    // Uniform rows, first run with continuous flow
    do_reset();
    for (int j = 0; j < NWORDS; j++) ws[j] = $urandom;
    cap.delete();
    capture = 1'b1;
    for (int j = 0; j < NWORDS; j++) send(ws[j], mkp(3), 1'b0);
    drain();
    capture = 1'b0;
    stream1 = cap;
    cap.delete();
    chk("run1_count", stream1.size(), NWORDS);

    cnt = '{0, 0, 0, 0};
    foreach (stream1[j]) begin
      for (int i = 0; i < LANES; i++) cnt[int'(stream1[j][2*i +: 2])]++;
    end
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("dist_nuc%0d_cnt%0d", n, cnt[n]),
          (cnt[n] >= 14720 && cnt[n] <= 17280) ? 1 : 0, 1);
    end

    // Reload the base seed, then replay with random stalls
    cyc(1'b0, '0, mkp(3), 1'b1, 1'b1, SEED);
    capture = 1'b1;
    for (int j = 0; j < NWORDS; j++) send(ws[j], mkp(3), 1'b1);
    drain();
    capture = 1'b0;
    chk("run2_count", cap.size(), NWORDS);
    mism = 0;
    for (int j = 0; j < NWORDS && j < cap.size(); j++) begin
      if (cap[j] !== stream1[j]) mism++;
    end
    chk("run2_stream_mismatches", mism, 0);
    cap.delete();

    // seed_load coinciding with an accept
    cyc(1'b1, ws[0], mkp(3), 1'b1, 1'b1, 32'h1234_5678);
    cyc(1'b1, ws[1], mkp(3), 1'b1, 1'b0, '0);
    drain();

    // Reset while two words are in flight
    cyc(1'b1, ws[2], mkp(3), 1'b0, 1'b0, '0);
    cyc(1'b1, ws[3], mkp(3), 1'b0, 1'b0, '0);
    chk("midrst_pre_valid", out_valid, 1);
    do_reset();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_final_result", final_result, 0);
    cyc(1'b1, ws[0], mkp(3), 1'b1, 1'b0, '0);
    cyc(1'b0, '0, mkp(3), 1'b1, 1'b0, '0);
    chk("midrst_first_valid", out_valid, 1);
    chk("midrst_first_result", final_result, stream1[0]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_ran_array.md
Name: pe_ran_array

Overview:
- Parametrised successor to the single-word random-mutation PE.
- Each cycle it accepts a word of LANES 2-bit nucleotides (A=00, C=01, G=10, T=11) plus a 4x4 substitution-probability matrix P.
- Per lane, it draws an independent pseudo-random number and replaces the nucleotide by sampling row P[orig].
- Adds valid/ready handshaking, a 2-stage pipeline with backpressure, reloadable per-lane LFSRs and a configurable lane count.
- Sits between the alignment word fetch and the write-back of the simulated sequence.

Parameters:
- LANES, 16, nucleotides per word; data width is 2*LANES.
- PROB_W, 10, bits per matrix entry.
- SCALE, 1000, value representing probability 1.0; a row of P must sum to SCALE.
- SEED, 32'hACE1_2468, base LFSR seed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_load  in  1  reloads all LFSRs from seed_in (synchronous, 1-cycle pulse).
- seed_in  in  32  seed used by seed_load.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input.
- nucl_alig  in  2*LANES  input nucleotides; lane i = bits [2i+1:2i].
- matrix_P  in  16*PROB_W  entry P[r][c] at bits [(4r+c)*PROB_W +: PROB_W]; captured with the word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- final_result  out  2*LANES  mutated nucleotides.

Behaviour:
- Reset state: out_valid=0, final_result=0, in_ready=1, both pipeline stages empty. Lane i LFSR = SEED ^ (i*32'h9E37_79B9); zero is replaced by 32'h1.
- Handshake:
  - Input accepted on in_valid & in_ready.
  - Output transferred on out_valid & out_ready.
  - final_result is held stable while out_valid & !out_ready.
- Pipeline:
  - S1 (on accept): latch word and P. Each lane computes r = (lfsr[15:0]*SCALE) >> 16, giving the range [0, SCALE-1]. Each lane LFSR then advances one step (Galois, taps 32'h8020_0003).
  - S2: per lane, with o = original nucleotide, compute cumulative sums C0..C3 over row P[o] at PROB_W+2 bits, so there is no overflow. Output the first c with r < Cc. If none, output o unchanged (row sums below SCALE fall back to the original nucleotide).
- Latency: 2 cycles from accept to out_valid when out_ready=1. Throughput is 1 word/cycle.
- Stall rules:
  - S2 advances when S2 is empty or out_ready=1.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready = S1 empty or S1 advancing (combinational from out_ready). There are no bubbles under continuous flow.
- LFSRs advance only on accepted inputs, so the result sequence is deterministic for a given seed and input order, independent of stalls.
- seed_load:
  - Lane i LFSR = seed_in ^ (i*32'h9E37_79B9), with zero replaced by 1.
  - If seed_load coincides with an accept, the accepted word uses the old LFSR value and the reload wins over the advance.
  - Pipeline contents are unaffected.
- Reset mid-operation: in-flight words are discarded and out_valid drops the next cycle. Reset has priority over seed_load.
- Entries greater than SCALE are legal; the sums saturate naturally by comparison.

Optional Feature:
- PE_RAN_MUTCOUNT_EN:
  - When defined, adds output mut_count (width $clog2(LANES+1)) = number of lanes where final_result differs from the original nucleotide. It is registered alongside final_result, has the same valid/hold rules, and resets to 0.
  - When undefined, the port and the logic are absent.

Decomposition:
- Package pe_ran_pkg:
  - nucleotide encoding constants NUC_A/C/G/T;
  - LFSR_TAPS and LANE_SEED_MIX constants;
  - function lane_seed(base, idx).
- One natural sub-module, pe_ran_lane, instantiated LANES times. It holds the LFSR, the scaled draw and the cumulative select; the top level holds the handshake and stage valids.

Test Plan:
- Identity matrix (P[r][r]=1000, rest 0), nucl_alig=32'h5165_2D55 -> final_result=32'h5165_2D55 after 2 cycles.
- All rows P[r][3]=1000, rest 0, any input -> final_result=32'hFFFF_FFFF; with PE_RAN_MUTCOUNT_EN, mut_count = number of non-T input lanes.
- All-zero P, input 32'hAAAA_AAAA -> output 32'hAAAA_AAAA (fallback path).
- Back-to-back 4 words, out_ready held low for cycles 3-7:
  - final_result stable during the stall;
  - in_ready=0 once both stages are full;
  - all 4 outputs delivered in order with no loss or duplication.
- Uniform rows (250 each):
  - 4000 words with SEED yield the same output stream as a second run with stalls inserted;
  - after seed_load with seed_in=SEED, the stream restarts identically;
  - per-nucleotide counts each fall in 25%±2%.
- Reset asserted while 2 words are in flight -> out_valid=0 the next cycle, final_result=0, and the first word after reset uses the reset LFSR state.
